// File: rtl/fft64_frame_serializer.sv
// Ping-pong frame serializer for a 64-point FFT. A whole 64-sample parallel
// frame is captured in one cycle and then streamed out one complex sample per
// cycle over a valid/ready handshake, optionally in bit-reversed read order.
module fft64_frame_serializer #(
  parameter int WIDTH  = 16,
  parameter int BITREV = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH*64-1:0]   in_re,
  input  logic [WIDTH*64-1:0]   in_im,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_re,
  output logic [WIDTH-1:0]      out_im,
  output logic [5:0]            out_idx,
  output logic                  out_last
);

  // Two frame banks; bank data is never reset, only the full flags qualify it.
  logic [WIDTH*64-1:0] re_mem [2];
  logic [WIDTH*64-1:0] im_mem [2];

  logic [1:0] full_q;
  logic       wr_bank_q;
  logic       rd_bank_q;
  logic [5:0] cnt_q;

  logic       accept;
  logic       step;
  logic       drain;
  logic [5:0] addr;

  function automatic logic [5:0] bitrev6(input logic [5:0] v);
    logic [5:0] r;
    for (int i = 0; i < 6; i++) begin
      r[i] = v[5-i];
    end
    return r;
  endfunction

  // Handshake decode; in_ready depends on registered state only.
  assign in_ready  = !full_q[wr_bank_q];
  assign out_valid = full_q[rd_bank_q];
  assign accept    = in_valid && in_ready;
  assign step      = out_valid && out_ready;
  assign drain     = step && (cnt_q == 6'd63);
  assign addr      = (BITREV != 0) ? bitrev6(cnt_q) : cnt_q;

  // Output mux: selected sample of the read bank, forced to zero when idle.
  always_comb begin
    out_re   = '0;
    out_im   = '0;
    out_idx  = '0;
    out_last = 1'b0;
    if (out_valid) begin
      out_re   = re_mem[rd_bank_q][int'(addr)*WIDTH +: WIDTH];
      out_im   = im_mem[rd_bank_q][int'(addr)*WIDTH +: WIDTH];
      out_idx  = cnt_q;
      out_last = (cnt_q == 6'd63);
    end
  end

  // Frame capture into the current write bank.
  always_ff @(posedge clk) begin
    if (accept) begin
      re_mem[wr_bank_q] <= in_re;
      im_mem[wr_bank_q] <= in_im;
    end
  end

  // Bank bookkeeping and read counter. An accept and a final drain in the same
  // cycle always touch different banks, so both flag updates apply.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full_q    <= 2'b00;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      cnt_q     <= 6'd0;
    end else begin
      if (accept) begin
        full_q[wr_bank_q] <= 1'b1;
        wr_bank_q         <= ~wr_bank_q;
      end
      if (drain) begin
        full_q[rd_bank_q] <= 1'b0;
        rd_bank_q         <= ~rd_bank_q;
        cnt_q             <= 6'd0;
      end else if (step) begin
        cnt_q <= cnt_q + 6'd1;
      end
    end
  end

endmodule
